// File: rtl/instr_pipe_stage_if.sv
// Bus for one instruction pipeline stage: control and data going in,
// registered valid/instruction/PC coming out.
interface instr_pipe_stage_if #(
    parameter int INSTR_W = 11,
    parameter int PC_W    = 6
);
    logic               en;
    logic               flush;
    logic               valid_in;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    counter_in;
    logic               valid_out;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    counter_out;

    modport master (
        output en, flush, valid_in, instr_in, counter_in,
        input  valid_out, instr_out, counter_out
    );

    modport slave (
        input  en, flush, valid_in, instr_in, counter_in,
        output valid_out, instr_out, counter_out
    );
endinterface

// File: rtl/instr_pipe_stage.sv
// Single registered instruction pipeline stage with stall and flush.
// Priority on each edge: reset, flush, stall, load.
module instr_pipe_stage #(
    parameter int                 INSTR_W  = 11,
    parameter int                 PC_W     = 6,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input logic                 clk,
    input logic                 reset_n,
    instr_pipe_stage_if.slave   bus
);
    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    counter_q;

    // Data is captured whether or not valid_in is set; valid only tags it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            instr_q   <= NOP_WORD;
            counter_q <= '0;
        end else if (bus.flush) begin
            valid_q   <= 1'b0;
            instr_q   <= NOP_WORD;
            counter_q <= '0;
        end else if (bus.en) begin
            valid_q   <= bus.valid_in;
            instr_q   <= bus.instr_in;
            counter_q <= bus.counter_in;
        end
    end

    assign bus.valid_out   = valid_q;
    assign bus.instr_out   = instr_q;
    assign bus.counter_out = counter_q;
endmodule

// File: tb/tb_instr_pipe_stage.sv
// Directed bench: single-stage behaviour on u0, plus a three-stage chain.
module tb_instr_pipe_stage;
    localparam int INSTR_W = 11;
    localparam int PC_W    = 6;

    logic clk = 1'b0;
    logic reset_n;
    logic en, flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_pipe_stage_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) if0 ();
    instr_pipe_stage_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) if1 ();
    instr_pipe_stage_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) if2 ();

    instr_pipe_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    instr_pipe_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    instr_pipe_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    assign if0.en = en;  assign if0.flush = flush;
    assign if1.en = en;  assign if1.flush = flush;
    assign if2.en = en;  assign if2.flush = flush;
    assign if1.valid_in   = if0.valid_out;
    assign if1.instr_in   = if0.instr_out;
    assign if1.counter_in = if0.counter_out;
    assign if2.valid_in   = if1.valid_out;
    assign if2.instr_in   = if1.instr_out;
    assign if2.counter_in = if1.counter_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_u0(input string tag, input logic [INSTR_W-1:0] i,
                            input logic [PC_W-1:0] c, input logic v);
        check({tag, ".instr"}, 32'(if0.instr_out), 32'(i));
        check({tag, ".pc"},    32'(if0.counter_out), 32'(c));
        check({tag, ".valid"}, 32'(if0.valid_out), 32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [INSTR_W-1:0] i, input logic [PC_W-1:0] c);
        if0.valid_in   = v;
        if0.instr_in   = i;
        if0.counter_in = c;
    endtask

    logic [INSTR_W-1:0] words [3];

    initial begin
        words[0] = 11'b11111111111;
        words[1] = 11'b00000000000;
        words[2] = 11'b11010110101;

        // reset overrides a pending load
        reset_n = 1'b0; en = 1'b1; flush = 1'b0;
        drive(1'b1, 11'h3C3, 6'd17);
        step();
        check_u0("reset", '0, '0, 1'b0);
        check("reset.u2.valid", 32'(if2.valid_out), 32'd0);

        // load: nothing visible until the edge
        reset_n = 1'b1;
        drive(1'b1, 11'b11111111111, 6'd5);
        #2;
        check_u0("load.before", '0, '0, 1'b0);
        step();
        check_u0("load.after", 11'h7FF, 6'd5, 1'b1);

        // invalid words still carry their data
        drive(1'b0, 11'h0F0, 6'd9);
        step();
        check_u0("invalid", 11'h0F0, 6'd9, 1'b0);

        // stall for three edges, then resume
        drive(1'b1, 11'h2AA, 6'd3);
        step();
        en = 1'b0;
        drive(1'b1, 11'h555, 6'd7);
        for (int k = 0; k < 3; k++) begin
            step();
            check_u0("stall", 11'h2AA, 6'd3, 1'b1);
        end
        en = 1'b1;
        step();
        check_u0("resume", 11'h555, 6'd7, 1'b1);

        // inputs wiggling between edges do not reach the outputs
        drive(1'b0, 11'h0AB, 6'd33);
        #3;
        check_u0("between", 11'h555, 6'd7, 1'b1);

        // flush wins over stall
        drive(1'b1, 11'h7FF, 6'd12);
        step();
        check_u0("preflush", 11'h7FF, 6'd12, 1'b1);
        flush = 1'b1; en = 1'b0;
        step();
        check_u0("flush", '0, '0, 1'b0);
        flush = 1'b0; en = 1'b1;

        // three-stage chain: stage 2 shows word j after edge j+2
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int e = 0; e < 6; e++) begin
            if (e < 3) drive(1'b1, words[e], 6'(e + 1));
            else       drive(1'b0, '0, '0);
            step();
            if (e < 2) begin
                check("chain.early.valid", 32'(if2.valid_out), 32'd0);
            end else if (e < 5) begin
                check("chain.instr", 32'(if2.instr_out), 32'(words[e-2]));
                check("chain.pc",    32'(if2.counter_out), 32'(e - 1));
                check("chain.valid", 32'(if2.valid_out), 32'd1);
            end else begin
                check("chain.tail.valid", 32'(if2.valid_out), 32'd0);
            end
        end

        // reset beats flush and load; next edge loads what is present
        reset_n = 1'b0; flush = 1'b1; en = 1'b1;
        drive(1'b1, 11'h123, 6'd40);
        step();
        check_u0("rstprio", '0, '0, 1'b0);
        reset_n = 1'b1; flush = 1'b0;
        step();
        check_u0("postrst", 11'h123, 6'd40, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
